instr_decode_ctrl: RTL and testbench
====================================

// Module: instr_decode_ctrl
// PURPOSE
//  Multi-cycle fetch/decode/execute controller; sits directly upstream of the register file.
//  - Fetches 16-bit instructions over a memory handshake and decodes them.
//  - Drives register-file indices, write/MOVI strobes and clk_en, plus ALU opcode and data-memory strobes.
//  - One instruction in flight at a time; no pipelining.
// PARAMETERS
//  PC_W      8       program counter width; imem address space is 2**PC_W words
// PORTS
//  clk_pi                  in   1      clock, rising edge
//  reset_n_pi              in   1      asynchronous reset, active-low
//  run_pi                  in   1      level; allows leaving IDLE
//  imem_rd_po              out  1      instruction fetch request
//  imem_addr_po            out  PC_W   fetch address (= PC)
//  imem_data_pi            in   16     instruction word
//  imem_valid_pi           in   1      imem_data_pi valid; completes fetch
//  dmem_rd_po              out  1      data read request (LOAD)
//  dmem_wr_po              out  1      data write request (STORE)
//  dmem_ack_pi             in   1      completes dmem_rd_po/dmem_wr_po
//  source_reg1_po          out  3      IR[8:6]
//  source_reg2_po          out  3      IR[5:3]
//  destination_reg_po      out  3      IR[11:9]
//  immediate_po            out  8      IR[7:0]
//  alu_op_po               out  4      IR[15:12]
//  result_sel_po           out  1      0 = ALU result, 1 = dmem read data to dest
//  clk_en_po               out  1      register-file clock enable (1-cycle pulse)
//  wr_destination_reg_po   out  1      register-file write strobe
//  movi_lower_po           out  1      MOVIL strobe
//  movi_higher_po          out  1      MOVIH strobe
//  flags_hold_po           out  1      1 = datapath feeds current flags back (non-ALU writes)
//  halted_po               out  1      sticky; set by HALT
//  pc_po                   out  PC_W   current PC
// BEHAVIOUR
//  Opcodes (IR[15:12]):
//   0 NOP | 1 ADD | 2 ADDC | 3 SUB | 4 SUBB | 5 AND | 6 OR | 7 XOR | 8 NOT
//   9 MOVIL | A MOVIH | B LOAD | C STORE | F HALT | D,E treated as NOP
//  Reset (async, reset_n_pi=0):
//   - state=IDLE, PC=0, IR=0.
//   - All strobes, request and flag outputs = 0; halted_po = 0.
//   - Applies mid-transaction; outstanding imem/dmem requests drop immediately.
//  FSM:
//   - IDLE:   run_pi=1 -> FETCH.
//   - FETCH:  imem_rd_po=1 held until imem_valid_pi=1 (same-cycle valid allowed);
//             latch IR on that edge -> DECODE.
//   - DECODE: 1 cycle; index outputs valid from here on -> EXEC.
//   - EXEC, ALU ops 1-8: one cycle, clk_en_po=1, wr_destination_reg_po=1, flags_hold_po=0;
//     PC+1 -> FETCH.
//   - EXEC, MOVIL/MOVIH: one cycle, clk_en_po=1, wr_destination_reg_po=1, matching movi_* =1,
//     flags_hold_po=1; PC+1 -> FETCH.
//   - EXEC, LOAD: dmem_rd_po=1 until dmem_ack_pi. On the ack cycle: clk_en_po=1,
//     wr_destination_reg_po=1, result_sel_po=1, flags_hold_po=1; PC+1 -> FETCH.
//   - EXEC, STORE: dmem_wr_po=1 until dmem_ack_pi; no clk_en_po, no write; PC+1 -> FETCH.
//   - EXEC, NOP/D/E: no strobes; PC+1 -> FETCH.
//   - EXEC, HALT: halted_po=1 -> HALTED.
//   - HALTED: absorbing; only reset exits. run_pi ignored.
//  run_pi deasserted mid-instruction: current instruction completes, then FETCH -> IDLE
//   (checked at FETCH entry only); PC is preserved.
//  Latency: ALU/MOVI = 3 cycles minimum (FETCH, DECODE, EXEC) with 0-wait imem.
//  PC wraps from 2**PC_W-1 to 0 without flagging.
//  dmem_ack_pi/imem_valid_pi outside their request states are ignored.
//  Strobes are registered-free decode of state+IR; never asserted outside EXEC.
// CONFIGURATION
//  INSTR_COUNT_EN defined:
//   - Adds output retired_cnt_po [15:0]: +1 per instruction leaving EXEC (incl. HALT).
//   - Reset to 0; wraps at 16'hFFFF -> 0.
//  INSTR_COUNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1. Reset with run_pi=1, imem returns ADD r3,r1,r2 (16'h1650), 0-wait
//     -> clk_en_po & wr_destination_reg_po high in cycle 3; dest=3, src1=1, src2=2; pc_po 0->1.
//  2. MOVIH r5,0xA5 (16'hAAA5) -> movi_higher_po=1, immediate_po=8'hA5, flags_hold_po=1, single pulse.
//  3. LOAD with dmem_ack_pi delayed 4 cycles
//     -> dmem_rd_po high 5 cycles; write strobe only on ack cycle with result_sel_po=1.
//  4. STORE, then HALT -> dmem_wr_po until ack, no clk_en_po; halted_po=1;
//     PC frozen; no further imem_rd_po despite run_pi=1.
//  5. Assert reset_n_pi=0 mid-LOAD wait -> dmem_rd_po and all strobes drop same cycle; pc_po=0, IDLE.
//  6. PC_W=2, four NOPs -> pc_po wraps 3->0; with INSTR_COUNT_EN, retired_cnt_po=4.

Source files
------------

// File: rtl/instr_decode_ctrl_if.sv
// Memory-side handshake bundle for instr_decode_ctrl: instruction fetch and data access.
// master = controller, slave = memory / testbench.
interface instr_decode_ctrl_if #(
  parameter int unsigned PC_W = 8
);
  logic            imem_rd_po;
  logic [PC_W-1:0] imem_addr_po;
  logic [15:0]     imem_data_pi;
  logic            imem_valid_pi;
  logic            dmem_rd_po;
  logic            dmem_wr_po;
  logic            dmem_ack_pi;

  modport master (
    output imem_rd_po, imem_addr_po, dmem_rd_po, dmem_wr_po,
    input  imem_data_pi, imem_valid_pi, dmem_ack_pi
  );

  modport slave (
    input  imem_rd_po, imem_addr_po, dmem_rd_po, dmem_wr_po,
    output imem_data_pi, imem_valid_pi, dmem_ack_pi
  );
endinterface

// File: rtl/instr_decode_ctrl.sv
// Multi-cycle fetch/decode/execute controller feeding the register file.
// One instruction in flight; strobes are a combinational decode of state and IR.
// Optional feature: define INSTR_COUNT_EN to add the retired-instruction counter
// output retired_cnt_po.
module instr_decode_ctrl #(
  parameter int unsigned PC_W = 8
) (
  input  logic                clk_pi,
  input  logic                reset_n_pi,
  input  logic                run_pi,
  instr_decode_ctrl_if.master mem,
  output logic [2:0]          source_reg1_po,
  output logic [2:0]          source_reg2_po,
  output logic [2:0]          destination_reg_po,
  output logic [7:0]          immediate_po,
  output logic [3:0]          alu_op_po,
  output logic                result_sel_po,
  output logic                clk_en_po,
  output logic                wr_destination_reg_po,
  output logic                movi_lower_po,
  output logic                movi_higher_po,
  output logic                flags_hold_po,
  output logic                halted_po,
  output logic [PC_W-1:0]     pc_po
`ifdef INSTR_COUNT_EN
  ,
  output logic [15:0]         retired_cnt_po
`endif
);

  typedef enum logic [2:0] {StIdle, StFetch, StDecode, StExec, StHalted} state_e;

  localparam logic [3:0] OpAdd   = 4'h1;
  localparam logic [3:0] OpAddc  = 4'h2;
  localparam logic [3:0] OpSub   = 4'h3;
  localparam logic [3:0] OpSubb  = 4'h4;
  localparam logic [3:0] OpAnd   = 4'h5;
  localparam logic [3:0] OpOr    = 4'h6;
  localparam logic [3:0] OpXor   = 4'h7;
  localparam logic [3:0] OpNot   = 4'h8;
  localparam logic [3:0] OpMovil = 4'h9;
  localparam logic [3:0] OpMovih = 4'hA;
  localparam logic [3:0] OpLoad  = 4'hB;
  localparam logic [3:0] OpStore = 4'hC;
  localparam logic [3:0] OpHalt  = 4'hF;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [3:0]      opcode;
  logic            exec_done;

  assign opcode = ir_q[15:12];

  // Instruction fields are decoded straight from IR; they are meaningful from DECODE on.
  assign alu_op_po          = opcode;
  assign destination_reg_po = ir_q[11:9];
  assign source_reg1_po     = ir_q[8:6];
  assign source_reg2_po     = ir_q[5:3];
  assign immediate_po       = ir_q[7:0];
  assign halted_po          = (state_q == StHalted);
  assign pc_po              = pc_q;
  assign mem.imem_addr_po   = pc_q;

  // State, PC and IR registers.
  always_ff @(posedge clk_pi or negedge reset_n_pi) begin
    if (!reset_n_pi) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state logic plus request and strobe decode.
  always_comb begin
    state_d               = state_q;
    pc_d                  = pc_q;
    ir_d                  = ir_q;
    mem.imem_rd_po        = 1'b0;
    mem.dmem_rd_po        = 1'b0;
    mem.dmem_wr_po        = 1'b0;
    clk_en_po             = 1'b0;
    wr_destination_reg_po = 1'b0;
    movi_lower_po         = 1'b0;
    movi_higher_po        = 1'b0;
    flags_hold_po         = 1'b0;
    result_sel_po         = 1'b0;
    exec_done             = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run_pi) state_d = StFetch;
      end
      StFetch: begin
        mem.imem_rd_po = 1'b1;
        if (mem.imem_valid_pi) begin
          ir_d    = mem.imem_data_pi;
          state_d = StDecode;
        end
      end
      StDecode: begin
        state_d = StExec;
      end
      StExec: begin
        exec_done = 1'b1;
        case (opcode)
          OpAdd, OpAddc, OpSub, OpSubb, OpAnd, OpOr, OpXor, OpNot: begin
            clk_en_po             = 1'b1;
            wr_destination_reg_po = 1'b1;
          end
          OpMovil, OpMovih: begin
            clk_en_po             = 1'b1;
            wr_destination_reg_po = 1'b1;
            movi_lower_po         = (opcode == OpMovil);
            movi_higher_po        = (opcode == OpMovih);
            flags_hold_po         = 1'b1;
          end
          OpLoad: begin
            mem.dmem_rd_po = 1'b1;
            exec_done      = mem.dmem_ack_pi;
            if (mem.dmem_ack_pi) begin
              clk_en_po             = 1'b1;
              wr_destination_reg_po = 1'b1;
              result_sel_po         = 1'b1;
              flags_hold_po         = 1'b1;
            end
          end
          OpStore: begin
            mem.dmem_wr_po = 1'b1;
            exec_done      = mem.dmem_ack_pi;
          end
          OpHalt: begin
            exec_done = 1'b0;
            state_d   = StHalted;
          end
          default: ;
        endcase
        // run_pi is only sampled here, so a deasserted run parks in IDLE before the next fetch.
        if (exec_done) begin
          pc_d    = pc_q + PC_W'(1);
          state_d = run_pi ? StFetch : StIdle;
        end
      end
      StHalted: ;
      default: state_d = StIdle;
    endcase
  end

`ifdef INSTR_COUNT_EN
  logic [15:0] cnt_q;
  logic        retire;

  // Any exit from EXEC (including into HALTED) retires one instruction.
  assign retire         = (state_q == StExec) && (state_d != StExec);
  assign retired_cnt_po = cnt_q;

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk_pi or negedge reset_n_pi) begin
    if (!reset_n_pi) cnt_q <= '0;
    else if (retire) cnt_q <= cnt_q + 16'd1;
  end
`endif

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// Randomized scoreboard bench for instr_decode_ctrl.
module tb_instr_decode_ctrl;
  localparam int unsigned PC_W = 8;
  localparam int N = 300;

  logic clk, rst_n, run;
  logic [2:0] src1, src2, dest;
  logic [7:0] imm;
  logic [3:0] alu_op;
  logic result_sel, clk_en, wr_dest, movil, movih, flags_hold, halted;
  logic [PC_W-1:0] pc;
`ifdef INSTR_COUNT_EN
  logic [15:0] retired_cnt;
`endif

  instr_decode_ctrl_if #(.PC_W(PC_W)) mem_if ();

  instr_decode_ctrl #(.PC_W(PC_W)) dut (
    .clk_pi                (clk),
    .reset_n_pi            (rst_n),
    .run_pi                (run),
    .mem                   (mem_if),
    .source_reg1_po        (src1),
    .source_reg2_po        (src2),
    .destination_reg_po    (dest),
    .immediate_po          (imm),
    .alu_op_po             (alu_op),
    .result_sel_po         (result_sel),
    .clk_en_po             (clk_en),
    .wr_destination_reg_po (wr_dest),
    .movi_lower_po         (movil),
    .movi_higher_po        (movih),
    .flags_hold_po         (flags_hold),
    .halted_po             (halted),
    .pc_po                 (pc)
`ifdef INSTR_COUNT_EN
    ,
    .retired_cnt_po        (retired_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_bad = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void fail_now(string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: event not expected or not seen (t=%0t)", name, $time);
  endfunction

  // Program and scoreboard queues.
  logic [15:0]     prog [N];
  int              prog_len = 0;
  int              idx = 0;
  logic [PC_W-1:0] exp_addr [$];
  logic [25:0]     exp_wr [$];
  bit              exp_dm [$];

  // Reference model: what every instruction must produce, from its opcode and fields.
  task automatic build_model();
    logic [3:0] op;
    logic [15:0] w;
    exp_addr.delete(); exp_wr.delete(); exp_dm.delete();
    for (int k = 0; k < prog_len; k++) begin
      w  = prog[k];
      op = w[15:12];
      exp_addr.push_back(PC_W'(k % (1 << PC_W)));
      if (op >= 4'h1 && op <= 4'hB)
        exp_wr.push_back({1'b1, op, w[11:9], w[8:6], w[5:3], w[7:0],
                          op == 4'h9, op == 4'hA, op >= 4'h9, op == 4'hB});
      if (op == 4'hB || op == 4'hC) exp_dm.push_back(op == 4'hC);
    end
  endtask

  // Instruction memory: first fetch of a program is zero-wait, later ones random wait;
  // spurious valids are thrown in while no fetch is pending.
  initial begin
    mem_if.imem_valid_pi = 1'b0;
    mem_if.imem_data_pi  = '0;
    forever begin
      @(negedge clk);
      if (mem_if.imem_rd_po && idx < prog_len && (idx == 0 || $urandom_range(0, 2) != 0)) begin
        mem_if.imem_valid_pi = 1'b1;
        mem_if.imem_data_pi  = prog[idx];
        idx++;
      end else begin
        mem_if.imem_valid_pi = !mem_if.imem_rd_po && ($urandom_range(0, 3) == 0);
        mem_if.imem_data_pi  = 16'($urandom);
      end
    end
  end

  // Data memory: first access waits 4 cycles, later ones 0..4.
  int dm_cnt = 0, dm_wait = 0, dm_seen = 0;
  bit no_ack = 1'b0;
  initial begin
    mem_if.dmem_ack_pi = 1'b0;
    forever begin
      @(negedge clk);
      if ((mem_if.dmem_rd_po || mem_if.dmem_wr_po) && !no_ack) begin
        if (dm_cnt == 0) begin
          dm_wait = (dm_seen == 0) ? 4 : int'($urandom_range(0, 4));
          dm_seen++;
        end
        if (dm_cnt == dm_wait) begin
          mem_if.dmem_ack_pi = 1'b1;
          dm_cnt = 0;
        end else begin
          mem_if.dmem_ack_pi = 1'b0;
          dm_cnt++;
        end
      end else begin
        mem_if.dmem_ack_pi = !no_ack && !(mem_if.dmem_rd_po || mem_if.dmem_wr_po) &&
                             ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Monitor: pops expectations whenever the DUT fetches, writes or completes a dmem access.
  bit mon_en = 1'b0;
  bit first_pending = 1'b1;
  int cyc = 0;
  int req_len = 0;
  initial begin
    logic [25:0] act_wr;
    logic [PC_W-1:0] ea;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n || !mon_en) begin
        cyc = 0;
        req_len = 0;
        continue;
      end
      if (mem_if.imem_rd_po && mem_if.imem_valid_pi) begin
        if (exp_addr.size() == 0) fail_now("fetch_unexpected");
        else begin
          ea = exp_addr.pop_front();
          check("fetch_addr", 64'(mem_if.imem_addr_po), 64'(ea));
          check("pc_at_fetch", 64'(pc), 64'(ea));
        end
      end
      if (clk_en) begin
        if (first_pending) begin
          check("first_write_cycle", 64'(cyc), 64'(3));
          first_pending = 1'b0;
        end
        act_wr = {wr_dest, alu_op, dest, src1, src2, imm, movil, movih, flags_hold, result_sel};
        if (exp_wr.size() == 0) fail_now("write_unexpected");
        else check("write_strobes", 64'(act_wr), 64'(exp_wr.pop_front()));
      end else begin
        check("idle_strobes", 64'({wr_dest, movil, movih, flags_hold, result_sel}), 64'(0));
      end
      if (mem_if.dmem_rd_po || mem_if.dmem_wr_po) begin
        req_len++;
        if (mem_if.dmem_rd_po && mem_if.dmem_wr_po) fail_now("dmem_rd_and_wr");
        if (mem_if.dmem_ack_pi) begin
          if (exp_dm.size() == 0) fail_now("dmem_unexpected");
          else check("dmem_kind_wr", 64'(mem_if.dmem_wr_po), 64'(exp_dm.pop_front()));
          check("dmem_req_len", 64'(req_len), 64'(dm_wait + 1));
          req_len = 0;
        end
      end else begin
        req_len = 0;
      end
      cyc++;
    end
  end

  initial begin
    logic [15:0] w;
    int t;
    rst_n = 1'b0;
    run   = 1'b1;
    prog[0] = 16'h1650;        // ADD r3,r1,r2
    prog[1] = 16'hAAA5;        // MOVIH r5,0xA5
    prog[2] = 16'hB4C0;        // LOAD, ack delayed 4
    prog[3] = 16'hC2C8;        // STORE
    for (int k = 4; k < N - 1; k++) begin
      w = 16'($urandom);
      if (w[15:12] == 4'hF) w[15:12] = 4'h0;
      prog[k] = w;
    end
    prog[N-1] = 16'hF000;      // HALT
    prog_len = N;
    idx = 0;
    build_model();
    mon_en = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    check("rst_pc", 64'(pc), 64'(0));
    check("rst_imem_rd", 64'(mem_if.imem_rd_po), 64'(0));
    check("rst_strobes", 64'({clk_en, wr_dest, movil, movih, flags_hold, result_sel,
                              mem_if.dmem_rd_po, mem_if.dmem_wr_po, halted}), 64'(0));
    check("rst_ir_fields", 64'({alu_op, dest, src1, src2, imm}), 64'(0));

    @(negedge clk);
    rst_n = 1'b1;

    // Run to HALT, dropping run_pi twice to park the controller in IDLE.
    t = 0;
    while (!halted && t < 20000) begin
      @(negedge clk);
      t++;
      if (t == 300 || t == 800) begin
        run = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        check("run_low_no_fetch", 64'(mem_if.imem_rd_po), 64'(0));
        run = 1'b1;
        t += 40;
      end
    end
    if (!halted) fail_now("halt_timeout");
    #1;
    check("halted", 64'(halted), 64'(1));
    check("halt_pc", 64'(pc), 64'((N - 1) % (1 << PC_W)));
    check("fetch_queue_drained", 64'(exp_addr.size()), 64'(0));
    check("write_queue_drained", 64'(exp_wr.size()), 64'(0));
    check("dmem_queue_drained", 64'(exp_dm.size()), 64'(0));
`ifdef INSTR_COUNT_EN
    check("retired_cnt", 64'(retired_cnt), 64'(N));
`endif
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      check("halted_no_fetch", 64'(mem_if.imem_rd_po), 64'(0));
      check("halted_pc_frozen", 64'(pc), 64'((N - 1) % (1 << PC_W)));
      check("halted_sticky", 64'(halted), 64'(1));
    end

    // Reset in the middle of a LOAD wait.
    mon_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    no_ack = 1'b1;
    dm_cnt = 0;
    prog[0] = 16'hB400;
    prog_len = 1;
    idx = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    while (!mem_if.dmem_rd_po && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!mem_if.dmem_rd_po) fail_now("load_wait_timeout");
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midload_rst_dmem", 64'({mem_if.dmem_rd_po, mem_if.dmem_wr_po}), 64'(0));
    check("midload_rst_strobes", 64'({clk_en, wr_dest, movil, movih, flags_hold,
                                      result_sel, halted, mem_if.imem_rd_po}), 64'(0));
    check("midload_rst_pc", 64'(pc), 64'(0));
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check("idle_after_rst", 64'({mem_if.imem_rd_po, mem_if.dmem_rd_po}), 64'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
